// File: rtl/icache_pkg.sv
// Shared state encoding, widths and address-field slicing macros for the icache.
// The optional ICACHE_PERF_CNT_EN build adds hit/miss counters in icache.
`ifndef ICACHE_PKG_MACROS
`define ICACHE_PKG_MACROS
`define ICACHE_WORD(addr, wb)           addr[(wb)+1:2]
`define ICACHE_INDEX(addr, wb, ib)      addr[(wb)+(ib)+1:(wb)+2]
`define ICACHE_TAG(addr, wb, ib, aw)    addr[(aw)-1:(wb)+(ib)+2]
`endif

package icache_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ICACHE_IDLE,
    ICACHE_REFILL,
    ICACHE_RESPOND
  } icache_state_t;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped icache: one write port, one
// combinational read port. Only the valid bits are reset.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2,
  parameter int TAG_BITS   = 22
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  wr_set_valid_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [WORD_BITS-1:0]  wr_word_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [INST_WIDTH-1:0] wr_data_i,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  input  logic [WORD_BITS-1:0]  rd_word_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [INST_WIDTH-1:0] rd_data_o
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [INST_WIDTH-1:0] data_q [LINES][WORDS];

  // Tag and valid are committed together with the final word of a line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_set_valid_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_index_i][wr_word_i] <= wr_data_i;
      if (wr_set_valid_i) begin
        tag_q[wr_index_i] <= wr_tag_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Define ICACHE_PERF_CNT_EN to add the perf_hit/perf_miss counter outputs.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2,
  parameter int ADDR_WIDTH = icache_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic                  if_enable,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [INST_WIDTH-1:0] mem_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           perf_hit,
  output logic [31:0]           perf_miss
`endif
);

  localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - WORD_BITS - 2;
  localparam int LINE_BITS = ADDR_WIDTH - WORD_BITS - 2;

  icache_state_t         state_q;
  logic                  if_valid_q;
  logic [INST_WIDTH-1:0] if_inst_q;
  logic                  mem_enable_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WORD_BITS-1:0]  cnt_q;
  logic [WORD_BITS-1:0]  word_q;
  logic [LINE_BITS-1:0]  line_q;
  logic                  cancel_q;
  logic                  clear_q;

  logic [LINE_BITS-1:0]  pc_line;
  logic [INDEX_BITS-1:0] rd_index;
  logic [WORD_BITS-1:0]  rd_word;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INST_WIDTH-1:0] rd_data;
  logic                  hit;
  logic                  accept;
  logic                  wr_en;
  logic                  last_word;
  logic                  unused_pc_bits;

  assign pc_line        = if_pc[ADDR_WIDTH-1:WORD_BITS+2];
  assign unused_pc_bits = ^if_pc[1:0];

  // RESPOND reads the latched request; IDLE looks up the live pc.
  assign rd_index = (state_q == ICACHE_RESPOND) ? line_q[INDEX_BITS-1:0]
                                                : `ICACHE_INDEX(if_pc, WORD_BITS, INDEX_BITS);
  assign rd_word  = (state_q == ICACHE_RESPOND) ? word_q : `ICACHE_WORD(if_pc, WORD_BITS);

  assign hit       = rd_valid && (rd_tag == `ICACHE_TAG(if_pc, WORD_BITS, INDEX_BITS, ADDR_WIDTH));
  assign accept    = rdy && (state_q == ICACHE_IDLE) && if_enable && !clear
                     && !if_valid_q && !clear_q;
  assign wr_en     = rdy && (state_q == ICACHE_REFILL) && mem_enable_q && mem_valid;
  assign last_word = (cnt_q == {WORD_BITS{1'b1}});

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .WORD_BITS  (WORD_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_line_store (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_en_i        (wr_en),
    .wr_set_valid_i (last_word),
    .wr_index_i     (line_q[INDEX_BITS-1:0]),
    .wr_word_i      (cnt_q),
    .wr_tag_i       (line_q[LINE_BITS-1:INDEX_BITS]),
    .wr_data_i      (mem_data),
    .rd_index_i     (rd_index),
    .rd_word_i      (rd_word),
    .rd_valid_o     (rd_valid),
    .rd_tag_o       (rd_tag),
    .rd_data_o      (rd_data)
  );

  // mem_enable drops for one cycle after each returned word before the next address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ICACHE_IDLE;
      if_valid_q   <= 1'b0;
      if_inst_q    <= '0;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      line_q       <= '0;
      cancel_q     <= 1'b0;
      clear_q      <= 1'b0;
    end else if (rdy) begin
      clear_q <= clear;
      case (state_q)
        ICACHE_IDLE: begin
          if_valid_q <= 1'b0;
          if (accept && hit) begin
            if_valid_q <= 1'b1;
            if_inst_q  <= rd_data;
          end else if (accept) begin
            line_q       <= pc_line;
            word_q       <= `ICACHE_WORD(if_pc, WORD_BITS);
            cnt_q        <= '0;
            cancel_q     <= 1'b0;
            mem_enable_q <= 1'b1;
            mem_addr_q   <= {pc_line, {(WORD_BITS+2){1'b0}}};
            state_q      <= ICACHE_REFILL;
          end
        end
        ICACHE_REFILL: begin
          if (clear) begin
            cancel_q <= 1'b1;
          end
          if (mem_enable_q && mem_valid) begin
            mem_enable_q <= 1'b0;
            if (last_word) begin
              state_q <= (cancel_q || clear) ? ICACHE_IDLE : ICACHE_RESPOND;
            end else begin
              cnt_q <= cnt_q + WORD_BITS'(1);
            end
          end else if (!mem_enable_q) begin
            mem_enable_q <= 1'b1;
            mem_addr_q   <= {line_q, cnt_q, 2'b00};
          end
        end
        ICACHE_RESPOND: begin
          if_valid_q <= !clear;
          if (!clear) begin
            if_inst_q <= rd_data;
          end
          cancel_q <= 1'b0;
          state_q  <= ICACHE_IDLE;
        end
        default: begin
          state_q <= ICACHE_IDLE;
        end
      endcase
    end
  end

  assign if_valid   = if_valid_q;
  assign if_inst    = if_inst_q;
  assign mem_enable = mem_enable_q;
  assign mem_addr   = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (accept) begin
      if (hit) begin
        perf_hit_q <= perf_hit_q + 32'd1;
      end else begin
        perf_miss_q <= perf_miss_q + 32'd1;
      end
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table-driven fetches plus hand-written
// sequences for clear, rdy stall and reset during a refill.
module tb_icache;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          miss;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        clear_seq;
  logic        clear_last;
  logic        if_enable;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        mem_enable;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  int          mem_wait = 0;
  bit          mem_stall = 1'b0;
  bit          arm_clear_last = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  vec_t        vecs[10];

  localparam int MEM_LAT = 2;

  assign clear = clear_seq | clear_last;

  always #5 clk = ~clk;

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .if_enable  (if_enable),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .mem_enable (mem_enable),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data)
  );

  // Backing memory contents: the first line holds the known 0x11..0x44 words.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {30'b0, a[3:2]} + 32'd1;
    if (a < 32'h10) return 32'h11 * w;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Memory controller model: answers each mem_enable after MEM_LAT cycles and
  // checks the requested address against the expected refill order.
  initial begin
    mem_valid  = 1'b0;
    mem_data   = '0;
    clear_last = 1'b0;
    forever begin
      @(negedge clk);
      clear_last = 1'b0;
      if (mem_valid) begin
        mem_valid = 1'b0;
      end else if (rst) begin
        mem_wait = 0;
      end else if (mem_enable && rdy && !mem_stall) begin
        if (mem_wait < MEM_LAT) begin
          mem_wait++;
        end else begin
          mem_wait = 0;
          if (exp_addr_q.size() == 0) begin
            checkOutput("unexpected_mem_read", mem_addr, 32'hFFFF_FFFF);
          end else begin
            checkOutput("mem_addr", mem_addr, exp_addr_q.pop_front());
          end
          mem_valid = 1'b1;
          mem_data  = mem_word(mem_addr);
          if (arm_clear_last && exp_addr_q.size() == 0) begin
            clear_last     = 1'b1;
            arm_clear_last = 1'b0;
          end
        end
      end
    end
  end

  // Response scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (if_valid === 1'b1) begin
        valid_cnt++;
        if (exp_inst_q.size() == 0) begin
          checkOutput("unexpected_if_valid", 32'd1, 32'd0);
        end else begin
          checkOutput("if_inst", if_inst, exp_inst_q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst,
                               input bit miss, input bit resp);
    logic [31:0] base;
    @(negedge clk);
    if_pc     = pc;
    if_enable = 1'b1;
    base      = {pc[31:4], 4'b0000};
    if (miss) begin
      for (int w = 0; w < 4; w++) exp_addr_q.push_back(base + 32'(4 * w));
    end
    if (resp) exp_inst_q.push_back(inst);
  endtask

  task automatic waitResponse(input bit check_lat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (if_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput("resp_timeout", 32'd0, 32'd1);
      if_enable = 1'b0;
      exp_inst_q.delete();
      return;
    end
    if (check_lat) checkOutput("hit_latency", 32'(lat), 32'd1);
    // Fetcher still holds the same request for one more cycle.
    @(negedge clk);
    checkOutput("no_double_issue", {31'b0, if_valid}, 32'd0);
    if_enable = 1'b0;
    checkOutput("refill_words_left", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic waitAddrLeft(input int n);
    int k;
    k = 0;
    while (exp_addr_q.size() > n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_addr_q.size() > n) checkOutput("wait_refill", 32'(exp_addr_q.size()), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0;
    rst        = 1'b1;
    rdy        = 1'b1;
    clear_seq  = 1'b0;
    if_enable  = 1'b0;
    if_pc      = '0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0011, 1'b1};
    vecs[1] = '{32'h0000_0008, 32'h0000_0033, 1'b0};
    vecs[2] = '{32'h0000_000C, 32'h0000_0044, 1'b0};
    vecs[3] = '{32'h0000_0004, 32'h0000_0022, 1'b0};
    vecs[4] = '{32'h0000_0400, 32'hC0DE_0400, 1'b1};
    vecs[5] = '{32'h0000_0408, 32'hC0DE_0408, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0011, 1'b1};
    vecs[7] = '{32'h0000_1234, 32'hC0DE_1234, 1'b1};
    vecs[8] = '{32'h0000_1230, 32'hC0DE_1230, 1'b0};
    vecs[9] = '{32'h0000_0004, 32'h0000_0022, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_if_valid",   {31'b0, if_valid},   32'd0);
    checkOutput("reset_if_inst",    if_inst,             32'd0);
    checkOutput("reset_mem_enable", {31'b0, mem_enable}, 32'd0);
    checkOutput("reset_mem_addr",   mem_addr,            32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].pc, vecs[i].inst, vecs[i].miss, 1'b1);
      waitResponse(!vecs[i].miss);
      repeat (2) @(negedge clk);
    end

    // Clear after the second word returns: refill completes silently.
    v0 = valid_cnt;
    applyStimulus(32'h0000_0404, 32'h0, 1'b1, 1'b0);
    waitAddrLeft(2);
    @(negedge clk);
    clear_seq = 1'b1;
    if_enable = 1'b0;
    @(negedge clk);
    clear_seq = 1'b0;
    waitAddrLeft(0);
    repeat (8) @(negedge clk);
    checkOutput("clear_refill_no_valid", 32'(valid_cnt - v0), 32'd0);
    checkOutput("clear_refill_words_left", 32'(exp_addr_q.size()), 32'd0);
    applyStimulus(32'h0000_0404, 32'hC0DE_0404, 1'b0, 1'b1);
    waitResponse(1'b1);
    repeat (2) @(negedge clk);

    // Clear coinciding with the last returned word.
    v0 = valid_cnt;
    arm_clear_last = 1'b1;
    applyStimulus(32'h0000_2000, 32'h0, 1'b1, 1'b0);
    waitAddrLeft(0);
    if_enable = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("clear_last_no_valid", 32'(valid_cnt - v0), 32'd0);
    applyStimulus(32'h0000_2008, 32'hC0DE_2008, 1'b0, 1'b1);
    waitResponse(1'b1);
    repeat (2) @(negedge clk);

    // rdy low while a word request is outstanding.
    applyStimulus(32'h0000_3008, 32'hC0DE_3008, 1'b1, 1'b1);
    waitAddrLeft(3);
    mem_stall = 1'b1;
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_mem_addr",   mem_addr,            32'h0000_3004);
      checkOutput("stall_mem_enable", {31'b0, mem_enable}, 32'd1);
    end
    rdy       = 1'b1;
    mem_stall = 1'b0;
    waitResponse(1'b0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a refill.
    applyStimulus(32'h0000_5000, 32'h0, 1'b1, 1'b0);
    waitAddrLeft(2);
    @(negedge clk);
    rst       = 1'b1;
    if_enable = 1'b0;
    @(negedge clk);
    checkOutput("midreset_if_valid",   {31'b0, if_valid},   32'd0);
    checkOutput("midreset_if_inst",    if_inst,             32'd0);
    checkOutput("midreset_mem_enable", {31'b0, mem_enable}, 32'd0);
    checkOutput("midreset_mem_addr",   mem_addr,            32'd0);
    exp_addr_q.delete();
    exp_inst_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(32'h0000_0404, 32'hC0DE_0404, 1'b1, 1'b1);
    waitResponse(1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(32'h0000_5004, 32'hC0DE_5004, 1'b1, 1'b1);
    waitResponse(1'b0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
